bpi_cmd_arbiter: RTL and testbench
==================================

BPI_CMD_ARBITER -- requirements
Module: bpi_cmd_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 40000000, meaning WAIT-state cycle limit (1 s at 40 MHz).
REQ-002 Parameter MAX_WORDS, default 2048, meaning maximum command words per transaction.
REQ-003 Clocking: one clock, CLK; reset RST, synchronous, active-high.
REQ-004 CLK  in  1  40 MHz clock.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 REQ  in  2  transaction request per requester; bit0 = VME port, bit1 = configuration controller.
REQ-007 WDATA0 / WDATA1  in  16  command word from requester 0 / 1.
REQ-008 WVALID  in  2  command word valid, per requester.
REQ-009 WLAST  in  2  marks final word of transaction, per requester.
REQ-010 GNT  out  2  one-hot grant; all zero when idle.
REQ-011 WREADY  out  1  word accepted when WVALID[g] and WREADY are both high (g = granted index).
REQ-012 BPI_CMD_FIFO_DATA  out  16  data to BPI command FIFO.
REQ-013 BPI_WE  out  1  command FIFO write strobe, one cycle per word.
REQ-014 BPI_DSBL / BPI_ENBL  out  1  parse disable / enable pulses.
REQ-015 BPI_CMD_FIFO_FULL  in  1  command FIFO full.
REQ-016 BPI_DONE  in  1  level; a rising edge marks completion of parsing.
REQ-017 BUSY  out  1  high in any state other than IDLE.
REQ-018 XFER_DONE  out  2  one-cycle pulse per requester on normal completion.
REQ-019 TIMEOUT / ABORT  out  1  one-cycle error pulses.
REQ-020 OVF  out  1  sticky flag: the word limit forced the end of the transaction.
REQ-021 WCNT  out  12  words accepted in the current or last transaction.

Function
REQ-022 States SHALL be IDLE, DSBL, LOAD, ENBL, WAIT and RELEASE.
REQ-023 IDLE: with any REQ bit high, the block SHALL select index g and enter DSBL on the next cycle.
REQ-024 Arbitration SHALL be round-robin: when both REQ bits are high, the requester not served last wins.
REQ-025 After reset, requester 0 SHALL have priority.
REQ-026 GNT[g] SHALL be high from DSBL through RELEASE inclusive.
REQ-027 On entering DSBL, OVF and WCNT SHALL clear.
REQ-028 DSBL SHALL assert BPI_DSBL for exactly one cycle, then enter LOAD.
REQ-029 LOAD: WREADY SHALL equal NOT BPI_CMD_FIFO_FULL; WREADY SHALL be 0 in every other state.
REQ-030 On an accepted word, the next cycle SHALL have BPI_WE = 1 and BPI_CMD_FIFO_DATA = accepted WDATAg (1-cycle latency).
REQ-031 On an accepted word, WCNT SHALL increment by 1.
REQ-032 BPI_CMD_FIFO_DATA SHALL hold its value between writes.
REQ-033 WVALID and WDATA of the non-granted requester SHALL be ignored.
REQ-034 An accepted word with WLAST[g] high SHALL move the block to ENBL.
REQ-035 An accepted word that brings WCNT to MAX_WORDS SHALL also move the block to ENBL, and SHALL set OVF if WLAST[g] is low.
REQ-036 ENBL SHALL assert BPI_ENBL for one cycle, in the cycle after the final BPI_WE, then enter WAIT with the timer cleared.
REQ-037 WAIT: the timer SHALL increment each cycle.
REQ-038 WAIT: a BPI_DONE rising edge (current high, previous-cycle registered low) SHALL move the block to RELEASE.
REQ-039 WAIT: timer = TIMEOUT_CYC-1 SHALL pulse TIMEOUT and move the block to RELEASE.
REQ-040 A BPI_DONE edge and timeout in the same cycle SHALL count as completion; TIMEOUT SHALL not pulse.
REQ-041 A BPI_DONE edge outside WAIT SHALL be ignored.
REQ-042 REQ[g] low in LOAD before the last word SHALL pulse ABORT and move the block to RELEASE with no BPI_ENBL.
REQ-043 A word accepted in the same cycle as REQ[g] going low SHALL still be written.
REQ-044 REQ[g] changes in DSBL, ENBL or WAIT SHALL be ignored.
REQ-045 RELEASE: XFER_DONE[g] SHALL pulse only if neither ABORT nor TIMEOUT occurred.
REQ-046 RELEASE: the round-robin pointer SHALL record g, GNT SHALL drop on the next cycle, and the block SHALL return to IDLE.
REQ-047 Minimum request-to-request turnaround SHALL be one IDLE cycle.

Reset
REQ-048 RST high SHALL, at the next CLK edge and from any state, force IDLE and clear the timer, WCNT and OVF.
REQ-049 RST high SHALL drive all outputs to 0 and point the round-robin pointer so requester 0 wins first.
REQ-050 A reset mid-transaction SHALL not emit BPI_ENBL, XFER_DONE, ABORT or TIMEOUT.

Verification
REQ-051 REQ=01, 3 words 0x1111/0x2222/0x3333 with LAST on the third, DONE edge 10 cycles after ENBL -> DSBL pulse, 3 BPI_WE with matching data, ENBL the cycle after the third WE, XFER_DONE[0], WCNT=3.
REQ-052 REQ=11 held for two back-to-back 1-word transactions -> grants in order 0 then 1 then 0; with REQ[1] alone after reset -> grant 1.
REQ-053 FULL high for 5 cycles mid-LOAD -> WREADY low, no BPI_WE during the stall, word order preserved.
REQ-054 TIMEOUT_CYC=16, DONE never rises -> TIMEOUT pulse exactly 16 cycles after entering WAIT, no XFER_DONE; DONE edge and timeout in the same cycle -> XFER_DONE only.
REQ-055 MAX_WORDS=4, 6 words without LAST -> 4 writes, OVF=1, ENBL issued; REQ dropped after 2 words -> ABORT pulse, no ENBL.
REQ-056 RST during LOAD after 2 words -> next cycle BUSY=0, GNT=00, WCNT=0, no ENBL.

Source files
------------

// File: rtl/bpi_cmd_arbiter_if.sv
// rtl/bpi_cmd_arbiter_if.sv - requester-side bundle for the BPI command arbiter
// Two requesters share one word stream; the arbiter grants one and paces it with wready.
interface bpi_cmd_arbiter_if;
   logic [1:0]  req;
   logic [15:0] wdata0;
   logic [15:0] wdata1;
   logic [1:0]  wvalid;
   logic [1:0]  wlast;
   logic [1:0]  gnt;
   logic        wready;

   modport master (
      output req, wdata0, wdata1, wvalid, wlast,
      input  gnt, wready
   );

   modport slave (
      input  req, wdata0, wdata1, wvalid, wlast,
      output gnt, wready
   );
endinterface

// File: rtl/bpi_cmd_arbiter.sv
// rtl/bpi_cmd_arbiter.sv - round-robin arbiter feeding command words into the BPI command FIFO
// Sequence per transaction: disable parser, load words, enable parser, wait for done or timeout.
module bpi_cmd_arbiter #(
   parameter int TIMEOUT_CYC = 40000000,
   parameter int MAX_WORDS   = 2048
) (
   input  logic              clk_i,
   input  logic              rst_i,
   bpi_cmd_arbiter_if.slave  req_if,
   output logic [15:0]       bpi_cmd_fifo_data_o,
   output logic              bpi_we_o,
   output logic              bpi_dsbl_o,
   output logic              bpi_enbl_o,
   input  logic              bpi_cmd_fifo_full_i,
   input  logic              bpi_done_i,
   output logic              busy_o,
   output logic [1:0]        xfer_done_o,
   output logic              timeout_o,
   output logic              abort_o,
   output logic              ovf_o,
   output logic [11:0]       wcnt_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_DSBL, S_LOAD, S_ENBL, S_WAIT, S_RELEASE
   } state_t;

   typedef enum logic [1:0] {
      R_DONE, R_TMO, R_ABT
   } reason_t;

   localparam int             TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [11:0]    WCNT_LAST = 12'(MAX_WORDS - 1);

   state_t         state_q, state_d;
   reason_t        reason_q, reason_d;
   logic           g_q, g_d;
   logic           last_q, last_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [11:0]    wcnt_q, wcnt_d;
   logic           ovf_q, ovf_d;
   logic           we_q, we_d;
   logic [15:0]    data_q, data_d;
   logic           enbl_q, enbl_d;
   logic           done_prev_q;

   logic [15:0]    wdata_g;
   logic           req_g;
   logic           wvalid_g;
   logic           wlast_g;
   logic           wready;
   logic           accept;
   logic           done_rise;

   assign wdata_g   = g_q ? req_if.wdata1 : req_if.wdata0;
   assign req_g     = req_if.req[g_q];
   assign wvalid_g  = req_if.wvalid[g_q];
   assign wlast_g   = req_if.wlast[g_q];
   assign wready    = (state_q == S_LOAD) && !bpi_cmd_fifo_full_i;
   assign accept    = wready && wvalid_g;
   assign done_rise = bpi_done_i && !done_prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         reason_q    <= R_DONE;
         g_q         <= 1'b0;
         last_q      <= 1'b1;
         timer_q     <= '0;
         wcnt_q      <= '0;
         ovf_q       <= 1'b0;
         we_q        <= 1'b0;
         data_q      <= '0;
         enbl_q      <= 1'b0;
         done_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         reason_q    <= reason_d;
         g_q         <= g_d;
         last_q      <= last_d;
         timer_q     <= timer_d;
         wcnt_q      <= wcnt_d;
         ovf_q       <= ovf_d;
         we_q        <= we_d;
         data_q      <= data_d;
         enbl_q      <= enbl_d;
         done_prev_q <= bpi_done_i;
      end
   end

   always_comb begin
      state_d  = state_q;
      reason_d = reason_q;
      g_d      = g_q;
      last_d   = last_q;
      timer_d  = timer_q;
      wcnt_d   = wcnt_q;
      ovf_d    = ovf_q;
      we_d     = accept;
      data_d   = accept ? wdata_g : data_q;
      enbl_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (|req_if.req) begin
               // Contention goes to whoever was not served last.
               g_d     = (req_if.req == 2'b11) ? ~last_q : req_if.req[1];
               wcnt_d  = '0;
               ovf_d   = 1'b0;
               state_d = S_DSBL;
            end
         end
         S_DSBL: state_d = S_LOAD;
         S_LOAD: begin
            if (accept) wcnt_d = wcnt_q + 12'd1;
            // A final word accepted in the same cycle as the request drop still completes.
            if (accept && (wlast_g || wcnt_q == WCNT_LAST)) begin
               ovf_d   = ovf_q | ~wlast_g;
               state_d = S_ENBL;
            end else if (!req_g) begin
               reason_d = R_ABT;
               state_d  = S_RELEASE;
            end
         end
         S_ENBL: begin
            enbl_d  = 1'b1;
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + 1'b1;
            if (done_rise) begin
               reason_d = R_DONE;
               state_d  = S_RELEASE;
            end else if (timer_q == TMO_LAST) begin
               reason_d = R_TMO;
               state_d  = S_RELEASE;
            end
         end
         S_RELEASE: begin
            last_d  = g_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req_if.gnt    = (state_q == S_IDLE) ? 2'b00 : (g_q ? 2'b10 : 2'b01);
   assign req_if.wready = wready;

   assign bpi_cmd_fifo_data_o = data_q;
   assign bpi_we_o            = we_q;
   assign bpi_dsbl_o          = (state_q == S_DSBL);
   assign bpi_enbl_o          = enbl_q;
   assign busy_o              = (state_q != S_IDLE);
   assign xfer_done_o         = (state_q == S_RELEASE && reason_q == R_DONE) ? req_if.gnt : 2'b00;
   assign timeout_o           = (state_q == S_RELEASE) && (reason_q == R_TMO);
   assign abort_o             = (state_q == S_RELEASE) && (reason_q == R_ABT);
   assign ovf_o               = ovf_q;
   assign wcnt_o              = wcnt_q;

endmodule

// File: tb/tb_bpi_cmd_arbiter.sv
// tb/tb_bpi_cmd_arbiter.sv - directed self-checking bench for bpi_cmd_arbiter
module tb_bpi_cmd_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        full;
   logic        done;
   logic [15:0] data;
   logic        we, dsbl, enbl, busy, timeout, abort, ovf;
   logic [1:0]  xfer_done;
   logic [11:0] wcnt;

   bpi_cmd_arbiter_if ifc ();

   bpi_cmd_arbiter #(.TIMEOUT_CYC(16), .MAX_WORDS(4)) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .req_if              (ifc),
      .bpi_cmd_fifo_data_o (data),
      .bpi_we_o            (we),
      .bpi_dsbl_o          (dsbl),
      .bpi_enbl_o          (enbl),
      .bpi_cmd_fifo_full_i (full),
      .bpi_done_i          (done),
      .busy_o              (busy),
      .xfer_done_o         (xfer_done),
      .timeout_o           (timeout),
      .abort_o             (abort),
      .ovf_o               (ovf),
      .wcnt_o              (wcnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          dsbl_cnt, enbl_cnt, xd_cnt, tmo_cnt, abt_cnt;
   int          enbl_cyc, last_we_cyc, tmo_cyc;
   logic [1:0]  xd_val;
   logic [15:0] wr_q[$];

   always @(negedge clk) begin
      if (we) begin
         wr_q.push_back(data);
         last_we_cyc = cyc;
      end
      if (dsbl) dsbl_cnt++;
      if (enbl) begin
         enbl_cnt++;
         enbl_cyc = cyc;
      end
      if (xfer_done != 2'b00) begin
         xd_cnt++;
         xd_val = xfer_done;
      end
      if (timeout) begin
         tmo_cnt++;
         tmo_cyc = cyc;
      end
      if (abort) abt_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic clear_log();
      dsbl_cnt = 0; enbl_cnt = 0; xd_cnt = 0; tmo_cnt = 0; abt_cnt = 0;
      enbl_cyc = 0; last_we_cyc = 0; tmo_cyc = 0; xd_val = 2'b00;
      wr_q.delete();
   endtask

   function automatic logic [15:0] wr_at(input int i);
      return (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
   endfunction

   task automatic wait_gnt(output int g);
      bit seen = 0;
      g = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ifc.gnt != 2'b00) begin
            seen = 1;
            g = int'(ifc.gnt[1]);
            break;
         end
      end
      check("gnt_seen", 32'(seen), 1);
   endtask

   task automatic wait_enbl();
      bit seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (enbl) begin
            seen = 1;
            break;
         end
      end
      check("enbl_seen", 32'(seen), 1);
   endtask

   task automatic wait_idle();
      bit seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) begin
            seen = 1;
            break;
         end
      end
      check("idle_seen", 32'(seen), 1);
   endtask

   task automatic send_word(input int g, input logic [15:0] d, input bit last,
                            input int budget, output bit ok);
      ok = 0;
      if (g == 0) ifc.wdata0 = d; else ifc.wdata1 = d;
      ifc.wvalid[g] = 1'b1;
      ifc.wlast[g]  = last;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (ifc.wready) ok = 1;
         @(negedge clk);
         if (ok) break;
      end
      ifc.wvalid[g] = 1'b0;
      ifc.wlast[g]  = 1'b0;
   endtask

   task automatic complete(input int delay);
      wait_enbl();
      repeat (delay) @(negedge clk);
      done = 1'b1;
      wait_idle();
      done = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int g;
      int acc;
      int extra;
      int e;
      int stall_rdy;
      int stall_we;
      bit ok;
      int gl[3];

      rst = 1'b1; full = 1'b0; done = 1'b0;
      ifc.req = 2'b00; ifc.wdata0 = '0; ifc.wdata1 = '0;
      ifc.wvalid = 2'b00; ifc.wlast = 2'b00;
      repeat (3) @(negedge clk);
      check("rst_busy",   32'(busy), 0);
      check("rst_gnt",    32'(ifc.gnt), 0);
      check("rst_wcnt",   32'(wcnt), 0);
      check("rst_we",     32'(we), 0);
      check("rst_wready", 32'(ifc.wready), 0);
      check("rst_ovf",    32'(ovf), 0);
      check("rst_data",   32'(data), 0);
      rst = 1'b0;
      @(negedge clk);

      // Three-word transaction from requester 0, done 10 cycles after enable.
      clear_log();
      ifc.req = 2'b01;
      wait_gnt(g);
      check("basic_gnt", 32'(ifc.gnt), 32'h1);
      acc = 0;
      send_word(0, 16'h1111, 0, 50, ok); acc += int'(ok);
      send_word(0, 16'h2222, 0, 50, ok); acc += int'(ok);
      send_word(0, 16'h3333, 1, 50, ok); acc += int'(ok);
      complete(10);
      ifc.req = 2'b00;
      check("basic_accepted", acc, 3);
      check("basic_dsbl_cnt", dsbl_cnt, 1);
      check("basic_we_cnt",   wr_q.size(), 3);
      check("basic_w0",       32'(wr_at(0)), 32'h1111);
      check("basic_w1",       32'(wr_at(1)), 32'h2222);
      check("basic_w2",       32'(wr_at(2)), 32'h3333);
      check("basic_enbl_cnt", enbl_cnt, 1);
      check("basic_enbl_lat", enbl_cyc - last_we_cyc, 1);
      check("basic_xd_cnt",   xd_cnt, 1);
      check("basic_xd_val",   32'(xd_val), 32'h1);
      check("basic_wcnt",     32'(wcnt), 3);
      check("basic_ovf",      32'(ovf), 0);
      check("basic_tmo",      tmo_cnt, 0);
      @(negedge clk);

      // FIFO full stall for 5 cycles in the middle of the load.
      clear_log();
      ifc.req = 2'b01;
      wait_gnt(g);
      send_word(0, 16'hA1A1, 0, 50, ok);
      full = 1'b1;
      ifc.wdata0 = 16'hB2B2;
      ifc.wvalid[0] = 1'b1;
      stall_rdy = 0; stall_we = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (ifc.wready) stall_rdy++;
         if (we) stall_we++;
      end
      full = 1'b0;
      acc = 0;
      send_word(0, 16'hB2B2, 0, 50, ok); acc += int'(ok);
      send_word(0, 16'hC3C3, 1, 50, ok); acc += int'(ok);
      complete(2);
      ifc.req = 2'b00;
      check("stall_wready", stall_rdy, 0);
      check("stall_we",     stall_we, 0);
      check("stall_acc",    acc, 2);
      check("stall_cnt",    wr_q.size(), 3);
      check("stall_w0",     32'(wr_at(0)), 32'hA1A1);
      check("stall_w1",     32'(wr_at(1)), 32'hB2B2);
      check("stall_w2",     32'(wr_at(2)), 32'hC3C3);
      @(negedge clk);

      // Timeout with DONE never rising.
      clear_log();
      ifc.req = 2'b01;
      wait_gnt(g);
      send_word(0, 16'h0F0F, 1, 50, ok);
      wait_enbl();
      e = cyc;
      wait_idle();
      ifc.req = 2'b00;
      check("tmo_cnt",   tmo_cnt, 1);
      check("tmo_delay", tmo_cyc - e, 16);
      check("tmo_xd",    xd_cnt, 0);
      check("tmo_abt",   abt_cnt, 0);
      @(negedge clk);

      // DONE edge in the same cycle as the timeout counts as completion.
      clear_log();
      ifc.req = 2'b01;
      wait_gnt(g);
      send_word(0, 16'h5A5A, 1, 50, ok);
      wait_enbl();
      repeat (15) @(negedge clk);
      done = 1'b1;
      wait_idle();
      done = 1'b0;
      ifc.req = 2'b00;
      check("race_xd",  xd_cnt, 1);
      check("race_tmo", tmo_cnt, 0);
      @(negedge clk);

      // Word limit of 4 reached without LAST.
      clear_log();
      ifc.req = 2'b01;
      wait_gnt(g);
      acc = 0; extra = 0;
      for (int i = 0; i < 4; i++) begin
         send_word(0, 16'hA000 + 16'(i), 0, 50, ok);
         acc += int'(ok);
      end
      for (int i = 4; i < 6; i++) begin
         send_word(0, 16'hA000 + 16'(i), 0, 3, ok);
         extra += int'(ok);
      end
      done = 1'b1;
      wait_idle();
      check("ovf_flag",  32'(ovf), 1);
      check("ovf_wcnt",  32'(wcnt), 4);
      done = 1'b0;
      ifc.req = 2'b00;
      check("ovf_acc",   acc, 4);
      check("ovf_extra", extra, 0);
      check("ovf_we",    wr_q.size(), 4);
      check("ovf_w3",    32'(wr_at(3)), 32'hA003);
      check("ovf_enbl",  enbl_cnt, 1);
      check("ovf_xd",    xd_cnt, 1);
      @(negedge clk);

      // Request dropped after two words.
      clear_log();
      ifc.req = 2'b01;
      wait_gnt(g);
      send_word(0, 16'hD001, 0, 50, ok);
      send_word(0, 16'hD002, 0, 50, ok);
      ifc.req = 2'b00;
      wait_idle();
      check("abt_cnt",  abt_cnt, 1);
      check("abt_enbl", enbl_cnt, 0);
      check("abt_xd",   xd_cnt, 0);
      check("abt_we",   wr_q.size(), 2);
      check("abt_ovf",  32'(ovf), 0);
      @(negedge clk);

      // Reset in the middle of LOAD.
      clear_log();
      ifc.req = 2'b01;
      wait_gnt(g);
      send_word(0, 16'hE001, 0, 50, ok);
      send_word(0, 16'hE002, 0, 50, ok);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_busy", 32'(busy), 0);
      check("mrst_gnt",  32'(ifc.gnt), 0);
      check("mrst_wcnt", 32'(wcnt), 0);
      rst = 1'b0;
      ifc.req = 2'b00;
      repeat (5) @(negedge clk);
      check("mrst_enbl", enbl_cnt, 0);
      check("mrst_abt",  abt_cnt, 0);
      check("mrst_xd",   xd_cnt, 0);
      check("mrst_tmo",  tmo_cnt, 0);

      // Both requesting after reset: grants 0, 1, 0.
      clear_log();
      ifc.req = 2'b11;
      for (int k = 0; k < 3; k++) begin
         wait_gnt(g);
         gl[k] = g;
         send_word(g, 16'hB000 + 16'(k), 1, 50, ok);
         complete(2);
      end
      ifc.req = 2'b00;
      check("rr_g0", gl[0], 0);
      check("rr_g1", gl[1], 1);
      check("rr_g2", gl[2], 0);
      check("rr_xd", xd_cnt, 3);
      check("rr_w1", 32'(wr_at(1)), 32'hB001);
      @(negedge clk);

      // Requester 1 alone right after reset.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_log();
      ifc.req = 2'b10;
      wait_gnt(g);
      check("r1_gnt", 32'(ifc.gnt), 32'h2);
      send_word(1, 16'h7777, 1, 50, ok);
      complete(2);
      ifc.req = 2'b00;
      check("r1_xd_val", 32'(xd_val), 32'h2);
      check("r1_w0",     32'(wr_at(0)), 32'h7777);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
